// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode constants for the IF/ID decoupling buffer.
package if_id_buf_pkg;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [31:0] NopInst     = ZeroWord;
  localparam logic        RstEnable   = 1'b0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
endpackage

// File: rtl/if_id_buf_fifo.sv
// Generic synchronous in-order FIFO with clear; storage is not reset, only control is.
module inst_fifo
  import if_id_buf_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/if_id_buf.sv
// IF->ID decoupling buffer: handshake gating, flush priority and NOP forcing around inst_fifo.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = InstAddrBus,
  parameter int DW    = InstBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic          flush,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  output logic          id_valid,
  input  logic          id_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             r_rst_n_q;
  logic             w_push;
  logic             w_pop;
  logic [AW+DW-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_empty;

  // Holds if_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) r_rst_n_q <= 1'b0;
    else                  r_rst_n_q <= 1'b1;
  end

  assign if_ready = (w_count != CW'(DEPTH)) & r_rst_n_q;
  assign id_valid = ~w_empty;
  assign w_push   = if_valid & if_ready & ~flush;
  assign w_pop    = id_valid & id_ready & ~flush;
  assign id_pc    = w_empty ? AW'(ZeroWord) : w_head[AW+DW-1:DW];
  assign id_inst  = w_empty ? DW'(NopInst)  : w_head[DW-1:0];

  inst_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  ({if_pc, if_inst}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: expected pairs queued on accept, compared on delivery.
module tb_if_id_buf;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];
  logic        model_live = 1'b0;

  if_id_buf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .flush    (flush),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .id_ready (id_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check against the model, update the model, cross the posedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    logic exp_valid, exp_ready;
    logic [63:0] head;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_inst = inst; id_ready = rdy; flush = fl;
    #1;
    exp_valid = (sb_q.size() != 0);
    exp_ready = model_live && (sb_q.size() != DEPTH);
    check("id_valid", {63'd0, id_valid}, {63'd0, exp_valid});
    check("if_ready", {63'd0, if_ready}, {63'd0, exp_ready});
    if (!exp_valid) check("id_nop", {id_pc, id_inst}, 64'd0);
    if (fl) begin
      sb_q.delete();
    end else begin
      if (exp_valid && rdy) begin
        head = sb_q.pop_front();
        check("id_pair", {id_pc, id_inst}, head);
      end
      if (exp_ready && v) sb_q.push_back({pc, inst});
    end
    @(posedge clk);
  endtask

  initial begin
    // 1: reset held three cycles, then release
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", {63'd0, id_valid}, 64'd0);
      check("rst_ready", {63'd0, if_ready}, 64'd0);
      check("rst_out", {id_pc, id_inst}, 64'd0);
    end
    @(negedge clk);
    flush = 1'b1;
    rst = 1'b1;
    #1;
    check("rel_ready0", {63'd0, if_ready}, 64'd0);
    flush = 1'b0;
    @(posedge clk);
    model_live = 1'b1;

    // 2: streaming, no gaps
    step(1, 32'h0, 32'hA, 1, 0);
    step(1, 32'h4, 32'hB, 1, 0);
    step(1, 32'h8, 32'hC, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // 3: stall and fill, held third pair
    step(1, 32'h0, 32'h10A, 0, 0);
    step(1, 32'h4, 32'h10B, 0, 0);
    step(1, 32'h8, 32'h10C, 0, 0);
    step(1, 32'h8, 32'h10C, 0, 0);
    step(1, 32'h8, 32'h10C, 1, 0);
    step(1, 32'h8, 32'h10C, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // 4: simultaneous push/pop at count 1
    step(1, 32'hC, 32'h20C, 0, 0);
    step(1, 32'h10, 32'h210, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    check("sb_count1", 64'(sb_q.size()), 64'd1);
    step(0, 32'h0, 32'h0, 1, 0);

    // 5: flush with count 2 and an incoming pair that must never appear
    step(1, 32'h18, 32'h318, 0, 0);
    step(1, 32'h1C, 32'h31C, 0, 0);
    step(1, 32'h20, 32'h320, 1, 1);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h24, 32'h324, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // random traffic with occasional flush
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 32'(i * 4), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    // 6: async reset between edges with count 2
    step(1, 32'h40, 32'h440, 0, 0);
    step(1, 32'h44, 32'h444, 0, 0);
    @(negedge clk);
    if_valid = 1'b0;
    check("pre_arst_valid", {63'd0, id_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {63'd0, id_valid}, 64'd0);
    check("arst_ready", {63'd0, if_ready}, 64'd0);
    check("arst_out", {id_pc, id_inst}, 64'd0);
    sb_q.delete();
    model_live = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_live = 1'b1;
    step(1, 32'h50, 32'h550, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
